// File: rtl/pulse_frame_pkg.sv
// rtl/pulse_frame_pkg.sv - shared types, defaults and width helpers for the serial pulse framer
package pulse_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_TAIL  = 2'd3
    } frame_state_e;

    localparam int DEF_NEUTRAL_CMD = 16;
    localparam int DEF_FRAME_CYC   = 1100000;

    // Counter width able to hold every frame position up to FRAME_CYC.
    function automatic int cnt_width(input int frame_cyc);
        return $clog2(frame_cyc + 1);
    endfunction

    function automatic int unsigned pulse_width(input int unsigned cmd,
                                                input int unsigned base_cyc,
                                                input int unsigned step_cyc);
        return base_cyc + cmd * step_cyc;
    endfunction

endpackage

// File: rtl/pulse_slew_ch.sv
// rtl/pulse_slew_ch.sv - one channel: pending/applied command registers with slew and failsafe override
module pulse_slew_ch
    import pulse_frame_pkg::*;
#(
    parameter int CMD_W       = 5,
    parameter int NEUTRAL_CMD = DEF_NEUTRAL_CMD,
    parameter int SLEW_MAX    = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             BOUNDARY,
    input  logic             FORCE_NEUTRAL,
    input  logic             CMD_VALID,
    input  logic [CMD_W-1:0] CMD,
    output logic [CMD_W-1:0] APPLIED
);

    localparam logic [CMD_W-1:0] NEUTRAL = CMD_W'(NEUTRAL_CMD);
    localparam logic [CMD_W-1:0] SLEW    = CMD_W'(SLEW_MAX);

    logic [CMD_W-1:0] pending;
    logic [CMD_W-1:0] applied_q;
    logic [CMD_W-1:0] target;
    logic [CMD_W-1:0] diff;
    logic [CMD_W-1:0] applied_n;
    logic             up;

    // A strobe landing on the boundary cycle wins over the stored pending value.
    always_comb begin
        target = pending;
        if (CMD_VALID) begin
            target = CMD;
        end else if (FORCE_NEUTRAL) begin
            target = NEUTRAL;
        end
        up        = (target > applied_q);
        diff      = up ? (target - applied_q) : (applied_q - target);
        applied_n = target;
        if ((SLEW_MAX != 0) && (32'(diff) > SLEW_MAX)) begin
            applied_n = up ? (applied_q + SLEW) : (applied_q - SLEW);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending   <= NEUTRAL;
            applied_q <= NEUTRAL;
        end else begin
            if (CMD_VALID) begin
                pending <= CMD;
            end else if (FORCE_NEUTRAL) begin
                pending <= NEUTRAL;
            end
            if (!ENABLE) begin
                applied_q <= NEUTRAL;
            end else if (BOUNDARY) begin
                applied_q <= applied_n;
            end
        end
    end

    assign APPLIED = applied_q;

endmodule

// File: rtl/serial_pulse_framer.sv
// rtl/serial_pulse_framer.sv - N-channel serial PWM frame generator with boundary latching, slew and timeout
module serial_pulse_framer
    import pulse_frame_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int CMD_W          = 5,
    parameter int FRAME_CYC      = DEF_FRAME_CYC,
    parameter int GAP_CYC        = 110000,
    parameter int BASE_CYC       = 100000,
    parameter int STEP_CYC       = 3125,
    parameter int NEUTRAL_CMD    = DEF_NEUTRAL_CMD,
    parameter int SLEW_MAX       = 0,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    ENABLE,
    input  logic [NUM_CH*CMD_W-1:0] CMD,
    input  logic                    CMD_VALID,
    output logic                    PWM,
    output logic                    FRAME_START,
    output logic                    FAILSAFE,
    output logic [NUM_CH*CMD_W-1:0] CUR_CMD
);

    localparam int CNT_W = cnt_width(FRAME_CYC);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TO_W  = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
    localparam longint BUSY_CYC =
        longint'(NUM_CH) * (longint'(BASE_CYC) + ((64'sd1 <<< CMD_W) - 1) * longint'(STEP_CYC))
        + longint'(NUM_CH - 1) * longint'(GAP_CYC);

    generate
        if ((BUSY_CYC >= longint'(FRAME_CYC)) || (GAP_CYC < 1)) begin : g_bad_timing
            $error("serial_pulse_framer: worst-case pulses and gaps do not fit in FRAME_CYC");
        end
    endgenerate

    frame_state_e            state;
    frame_state_e            state_n;
    logic [CNT_W-1:0]        k_cnt;
    logic [CNT_W-1:0]        seg_cnt;
    logic [CNT_W-1:0]        cur_w;
    logic [CH_W-1:0]         ch;
    logic [TO_W-1:0]         to_cnt;
    logic [CMD_W-1:0]        cur_cmd_sel;
    logic [NUM_CH*CMD_W-1:0] applied;
    logic                    failsafe_q;
    logic                    pwm_q;
    logic                    fs_q;
    logic                    pwm_d;
    logic                    fs_d;
    logic                    last_ch;
    logic                    seg_done;
    logic                    gap_done;
    logic                    wrap;
    logic                    boundary;
    logic                    fs_force;

    assign cur_cmd_sel = applied[ch*CMD_W +: CMD_W];
    assign cur_w       = CNT_W'(pulse_width(32'(cur_cmd_sel), BASE_CYC, STEP_CYC));
    assign last_ch     = (ch == CH_W'(NUM_CH - 1));
    assign seg_done    = (seg_cnt == cur_w - CNT_W'(1));
    assign gap_done    = (seg_cnt == CNT_W'(GAP_CYC - 1));
    assign wrap        = (state == ST_TAIL) && (k_cnt == CNT_W'(FRAME_CYC - 1));
    assign boundary    = wrap && ENABLE;
    assign fs_force    = (TIMEOUT_FRAMES != 0) && boundary && !CMD_VALID &&
                         (to_cnt >= TO_W'(TIMEOUT_FRAMES - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  state_n = ST_PULSE;
            ST_PULSE: if (seg_done) state_n = last_ch ? ST_TAIL : ST_GAP;
            ST_GAP:   if (gap_done) state_n = ST_PULSE;
            ST_TAIL:  if (wrap) state_n = ST_PULSE;
            default:  state_n = ST_IDLE;
        endcase
        if (!ENABLE) begin
            state_n = ST_IDLE;
        end
    end

    // Outputs are registered from the next state so PWM lines up with the frame counter.
    always_comb begin
        pwm_d = (state_n == ST_PULSE);
        fs_d  = pwm_d && ((state == ST_IDLE) || wrap);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_q <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
            fs_q  <= fs_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            k_cnt   <= '0;
            seg_cnt <= '0;
            ch      <= '0;
        end else if ((state_n == ST_IDLE) || (state == ST_IDLE) || wrap) begin
            k_cnt   <= '0;
            seg_cnt <= '0;
            ch      <= '0;
        end else begin
            k_cnt   <= k_cnt + CNT_W'(1);
            seg_cnt <= (state_n != state) ? '0 : seg_cnt + CNT_W'(1);
            if ((state == ST_GAP) && (state_n == ST_PULSE)) begin
                ch <= ch + CH_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt     <= '0;
            failsafe_q <= 1'b0;
        end else if (CMD_VALID) begin
            to_cnt     <= '0;
            failsafe_q <= 1'b0;
        end else begin
            if (boundary && (to_cnt < TO_W'(TIMEOUT_FRAMES))) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (fs_force) begin
                failsafe_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_slew_ch #(
            .CMD_W       (CMD_W),
            .NEUTRAL_CMD (NEUTRAL_CMD),
            .SLEW_MAX    (SLEW_MAX)
        ) u_ch (
            .CLK           (CLK),
            .RST_N         (RST_N),
            .ENABLE        (ENABLE),
            .BOUNDARY      (boundary),
            .FORCE_NEUTRAL (fs_force),
            .CMD_VALID     (CMD_VALID),
            .CMD           (CMD[i*CMD_W +: CMD_W]),
            .APPLIED       (applied[i*CMD_W +: CMD_W])
        );
    end

    assign PWM         = pwm_q;
    assign FRAME_START = fs_q;
    assign FAILSAFE    = failsafe_q;
    assign CUR_CMD     = applied;

endmodule

// File: tb/tb_serial_pulse_framer.sv
// tb/tb_serial_pulse_framer.sv - directed bench for serial_pulse_framer on a scaled-down frame
module tb_serial_pulse_framer;

    localparam int FRAME = 160;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       ENABLE;
    logic [9:0] CMD;
    logic       CMD_VALID;

    logic       pwm0, fs0, fsafe0;
    logic       pwm1, fs1, fsafe1;
    logic [9:0] cur0, cur1;

    int n_tests = 0;
    int n_fail  = 0;
    int m_w0[2], m_r1[2], m_w1[2], m_per[2], m_extra[2];

    always #5 CLK = ~CLK;

    serial_pulse_framer #(
        .NUM_CH(2), .CMD_W(5), .FRAME_CYC(FRAME), .GAP_CYC(5), .BASE_CYC(10),
        .STEP_CYC(2), .NEUTRAL_CMD(16), .SLEW_MAX(0), .TIMEOUT_FRAMES(8)
    ) dut0 (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .CMD(CMD), .CMD_VALID(CMD_VALID),
        .PWM(pwm0), .FRAME_START(fs0), .FAILSAFE(fsafe0), .CUR_CMD(cur0)
    );

    serial_pulse_framer #(
        .NUM_CH(2), .CMD_W(5), .FRAME_CYC(FRAME), .GAP_CYC(5), .BASE_CYC(10),
        .STEP_CYC(2), .NEUTRAL_CMD(16), .SLEW_MAX(1), .TIMEOUT_FRAMES(8)
    ) dut1 (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .CMD(CMD), .CMD_VALID(CMD_VALID),
        .PWM(pwm1), .FRAME_START(fs1), .FAILSAFE(fsafe1), .CUR_CMD(cur1)
    );

    function automatic logic [9:0] pk(input int c1, input int c0);
        return {5'(c1), 5'(c0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (fs0 !== 1'b1 && n < 4 * FRAME) begin
            @(negedge CLK);
            n++;
        end
        chk("frame_start_seen", fs0, 1);
    endtask

    // Record one frame of both PWM lines starting at k=0; optionally strobe CMD at k=strobe_k.
    task automatic grab(input int strobe_k, input logic [9:0] strobe_cmd);
        int   ph[2];
        logic p, f;
        wait_fs();
        for (int d = 0; d < 2; d++) begin
            m_w0[d] = 0; m_r1[d] = -1; m_w1[d] = 0; m_per[d] = -1; m_extra[d] = 0; ph[d] = 0;
        end
        for (int i = 0; i < FRAME; i++) begin
            if (i == strobe_k) begin
                CMD = strobe_cmd;
                CMD_VALID = 1'b1;
            end else if (i == strobe_k + 1) begin
                CMD_VALID = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                p = (d == 1) ? pwm1 : pwm0;
                f = (d == 1) ? fs1 : fs0;
                if (i > 0 && f && m_per[d] < 0) m_per[d] = i;
                case (ph[d])
                    0: if (p) m_w0[d]++; else ph[d] = 1;
                    1: if (p) begin m_r1[d] = i; m_w1[d] = 1; ph[d] = 2; end
                    2: if (p) m_w1[d]++; else ph[d] = 3;
                    default: if (p) m_extra[d]++;
                endcase
            end
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        if (m_per[0] < 0 && fs0) m_per[0] = FRAME;
        if (m_per[1] < 0 && fs1) m_per[1] = FRAME;
    endtask

    task automatic check_frame(input string tag, input int d, input int ew0, input int er1, input int ew1);
        chk({tag, "_w0"},    m_w0[d],    ew0);
        chk({tag, "_rise1"}, m_r1[d],    er1);
        chk({tag, "_w1"},    m_w1[d],    ew1);
        chk({tag, "_period"},m_per[d],   FRAME);
        chk({tag, "_tail"},  m_extra[d], 0);
    endtask

    initial begin
        RST_N = 1'b0; ENABLE = 1'b0; CMD = '0; CMD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_pwm", pwm0, 0);
        chk("rst_fs", fs0, 0);
        chk("rst_failsafe", fsafe0, 0);
        chk("rst_cur0", cur0, pk(16, 16));
        chk("rst_cur1", cur1, pk(16, 16));
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_pwm", pwm0, 0);
        ENABLE = 1'b1;
        @(negedge CLK);
        chk("start_pwm", pwm0, 1);
        chk("start_fs", fs0, 1);

        // Neutral frame; mid-frame command must not disturb it.
        grab(20, pk(16, 20));
        check_frame("A0", 0, 42, 47, 42);
        check_frame("A1", 1, 42, 47, 42);
        chk("B_cur0", cur0, pk(16, 20));
        chk("B_cur1", cur1, pk(16, 17));

        // Slew of 1 per frame on dut1, direct jump on dut0.
        for (int f = 0; f < 5; f++) begin
            grab(-1, '0);
            check_frame("slew0", 0, 50, 55, 42);
            check_frame("slew1", 1, 44 + 2 * ((f < 3) ? f : 3), 49 + 2 * ((f < 3) ? f : 3), 42);
        end
        chk("G_cur1", cur1, pk(16, 20));

        grab(20, pk(0, 31));
        check_frame("G0", 0, 50, 55, 42);
        check_frame("G1", 1, 50, 55, 42);
        chk("H_cur0", cur0, pk(0, 31));
        chk("H_cur1", cur1, pk(15, 21));
        grab(-1, '0);
        check_frame("H0", 0, 72, 77, 10);
        check_frame("H1", 1, 52, 57, 40);

        // Timeout: eighth boundary after the last strobe.
        chk("to_before", fsafe0, 0);
        repeat (6 * FRAME - 1) @(negedge CLK);
        chk("to_last_cycle", fsafe0, 0);
        @(negedge CLK);
        chk("to_rise0", fsafe0, 1);
        chk("to_rise1", fsafe1, 1);
        chk("to_fs", fs0, 1);
        chk("to_cur0", cur0, pk(16, 16));
        chk("to_cur1", cur1, pk(10, 26));
        grab(-1, '0);
        check_frame("FS0", 0, 42, 47, 42);
        check_frame("FS1", 1, 62, 67, 30);
        chk("fs_held", fsafe0, 1);
        CMD = pk(25, 5);
        CMD_VALID = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        chk("fs_clear0", fsafe0, 0);
        chk("fs_clear1", fsafe1, 0);

        // Enable drop during the ch0 pulse, then restart.
        wait_fs();
        repeat (10) @(negedge CLK);
        chk("en_pulse_high", pwm0, 1);
        ENABLE = 1'b0;
        @(negedge CLK);
        chk("en_drop_pwm0", pwm0, 0);
        chk("en_drop_pwm1", pwm1, 0);
        chk("en_drop_cur0", cur0, pk(16, 16));
        repeat (5) @(negedge CLK);
        chk("en_idle_pwm", pwm0, 0);
        chk("en_idle_fs", fs0, 0);
        ENABLE = 1'b1;
        @(negedge CLK);
        chk("reen_pwm", pwm0, 1);
        chk("reen_fs", fs0, 1);
        grab(-1, '0);
        check_frame("R0", 0, 42, 47, 42);
        check_frame("R1", 1, 42, 47, 42);
        chk("R1_cur0", cur0, pk(25, 5));
        chk("R1_cur1", cur1, pk(17, 15));

        // Strobe on the boundary cycle becomes the target immediately.
        grab(FRAME - 1, pk(31, 0));
        check_frame("S0", 0, 20, 25, 60);
        chk("S_cur0", cur0, pk(31, 0));
        chk("S_cur1", cur1, pk(18, 14));
        grab(-1, '0);
        check_frame("T0", 0, 10, 15, 72);

        // Asynchronous reset between clock edges.
        repeat (5) @(negedge CLK);
        chk("ar_pulse_high", pwm0, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("ar_pwm", pwm0, 0);
        chk("ar_fs", fs0, 0);
        chk("ar_failsafe", fsafe0, 0);
        chk("ar_cur0", cur0, pk(16, 16));
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("ar_restart_pwm", pwm0, 1);
        chk("ar_restart_fs", fs0, 1);
        grab(-1, '0);
        check_frame("AR0", 0, 42, 47, 42);
        check_frame("AR1", 1, 42, 47, 42);
        chk("AR_cur0", cur0, pk(16, 16));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
